// File: rtl/demux1x4_buf_pkg.sv
// -----------------------------------------------------------------------------
// demux1x4_buf_pkg
// Purpose : shared constants and helpers for the buffered 1-to-4 demux.
//   NUM_CH   - number of output channels
//   CH_DEPTH - entries per channel FIFO (also the "full" occupancy value)
//   ch_sel_e - channel-select encoding, same as mux4x1 (00 = first channel)
//   sel_decode() - 2-bit select to one-hot channel mask
// -----------------------------------------------------------------------------
package demux1x4_buf_pkg;

  localparam int         NUM_CH   = 4;
  localparam logic [1:0] CH_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    CH_OUT1 = 2'b00,
    CH_OUT2 = 2'b01,
    CH_OUT3 = 2'b10,
    CH_OUT4 = 2'b11
  } ch_sel_e;

  // One-hot decode of the channel select; bit k set means channel k.
  function automatic logic [NUM_CH-1:0] sel_decode(input logic [1:0] sel);
    logic [NUM_CH-1:0] oh;
    case (ch_sel_e'(sel))
      CH_OUT1: oh = 4'b0001;
      CH_OUT2: oh = 4'b0010;
      CH_OUT3: oh = 4'b0100;
      CH_OUT4: oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux1x4_buf_fifo2.sv
// -----------------------------------------------------------------------------
// fifo2
// Purpose : 2-entry FIFO with registered head, used once per demux channel.
// Ports   :
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset (clears count, pointers, storage)
//   push  - write din this edge (ignored when full)
//   pop   - drop the head entry this edge (ignored when empty)
//   din   - word to write
//   full  - occupancy == 2 (registered state only)
//   empty - occupancy == 0 (registered state only)
//   head  - entry at the read pointer (registered state only)
// -----------------------------------------------------------------------------
module fifo2
  import demux1x4_buf_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [width-1:0] head
);

  logic [1:0]       cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [width-1:0] mem_q [2];
  logic [width-1:0] mem_d [2];
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (cnt_q == CH_DEPTH);
  assign empty = (cnt_q == 2'd0);
  assign head  = mem_q[rd_q];

  // Next-state: gated push/pop so overflow and underflow cannot happen.
  always_comb begin
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    mem_d     = mem_q;
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;

    if (do_push_s) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;   // 1-bit pointer wraps 1 -> 0
    end else begin
      wr_d = wr_q;
    end

    if (do_pop_s) begin
      rd_d = ~rd_q;
    end else begin
      rd_d = rd_q;
    end

    // Push and pop together leave the count unchanged.
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      mem_q[0] <= {width{1'b0}};
      mem_q[1] <= {width{1'b0}};
    end else begin
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

endmodule

// File: rtl/demux1x4_buf.sv
// -----------------------------------------------------------------------------
// demux1x4_buf
// Purpose : route one valid/ready input stream to one of four output channels,
//           each buffered by a 2-entry FIFO.
// Ports   :
//   clk, rst                 - clock (rising edge), async active-high reset
//   in_valid/in_ready        - upstream handshake; in_ready reflects only the
//                              selected channel's occupancy
//   in_data [width]          - offered word
//   in_sel  [2]              - destination (00->out1 .. 11->out4)
//   outk_valid/outk_ready    - per-channel downstream handshake (k = 1..4)
//   outk   [width]           - head word of channel k (registered)
// -----------------------------------------------------------------------------
module demux1x4_buf
  import demux1x4_buf_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  output logic             out4_valid,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready,
  input  logic             out4_ready,
  output logic [width-1:0] out1,
  output logic [width-1:0] out2,
  output logic [width-1:0] out3,
  output logic [width-1:0] out4
);

  logic [NUM_CH-1:0] full_s;
  logic [NUM_CH-1:0] empty_s;
  logic [NUM_CH-1:0] push_s;
  logic [NUM_CH-1:0] pop_s;
  logic [NUM_CH-1:0] ready_s;
  logic [NUM_CH-1:0] sel_oh_s;
  logic [width-1:0]  head_s [NUM_CH];

  assign ready_s = {out4_ready, out3_ready, out2_ready, out1_ready};

  // Decode and handshake steering. A full channel never bypasses to the
  // output, so in_ready depends only on the registered full flags.
  always_comb begin
    sel_oh_s = sel_decode(in_sel);
    in_ready = !full_s[in_sel];
    if (in_valid && in_ready) begin
      push_s = sel_oh_s;
    end else begin
      push_s = {NUM_CH{1'b0}};
    end
    pop_s = ready_s & ~empty_s;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fifo2 #(.width(width)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s[g]),
      .pop   (pop_s[g]),
      .din   (in_data),
      .full  (full_s[g]),
      .empty (empty_s[g]),
      .head  (head_s[g])
    );
  end

  assign out1_valid = !empty_s[0];
  assign out2_valid = !empty_s[1];
  assign out3_valid = !empty_s[2];
  assign out4_valid = !empty_s[3];
  assign out1       = head_s[0];
  assign out2       = head_s[1];
  assign out3       = head_s[2];
  assign out4       = head_s[3];

endmodule

// File: tb/tb_demux1x4_buf.sv
// -----------------------------------------------------------------------------
// tb_demux1x4_buf
// Self-checking bench: directed scenarios plus a random soak, compared against
// a per-channel queue model of the buffered demux.
// -----------------------------------------------------------------------------
module tb_demux1x4_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic [1:0]  in_sel = 2'b00;
  logic [3:0]  rdy = 4'b0000;
  logic        out1_valid, out2_valid, out3_valid, out4_valid;
  logic [15:0] out1, out2, out3, out4;
  logic [3:0]  vld;
  logic [15:0] outs [4];

  int total = 0;
  int bad   = 0;

  // Reference model: one queue per channel, at most two words each.
  logic [15:0] mq [4][$];

  always #5 clk = ~clk;

  demux1x4_buf #(.width(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out1_valid (out1_valid),
    .out2_valid (out2_valid),
    .out3_valid (out3_valid),
    .out4_valid (out4_valid),
    .out1_ready (rdy[0]),
    .out2_ready (rdy[1]),
    .out3_ready (rdy[2]),
    .out4_ready (rdy[3]),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out4       (out4)
  );

  assign vld     = {out4_valid, out3_valid, out2_valid, out1_valid};
  assign outs[0] = out1;
  assign outs[1] = out2;
  assign outs[2] = out3;
  assign outs[3] = out4;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every visible output with what the model says.
  task automatic model_check();
    check_val("in_ready", {31'd0, in_ready}, {31'd0, (mq[in_sel].size() < 2)});
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("valid%0d", k + 1), {31'd0, vld[k]}, {31'd0, (mq[k].size() != 0)});
      if (mq[k].size() != 0)
        check_val($sformatf("out%0d", k + 1), {16'd0, outs[k]}, {16'd0, mq[k][0]});
    end
  endtask

  // Apply the handshake rules to the model for the current inputs.
  task automatic model_update();
    bit acc;
    acc = in_valid && (mq[in_sel].size() < 2);
    for (int k = 0; k < 4; k++)
      if (rdy[k] && mq[k].size() != 0) void'(mq[k].pop_front());
    if (acc) mq[in_sel].push_back(in_data);
  endtask

  task automatic step_begin(input logic v, input logic [1:0] s, input logic [15:0] d,
                            input logic [3:0] r);
    @(negedge clk);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    rdy      = r;
    #1;
    model_check();
  endtask

  task automatic step_end();
    @(posedge clk);
    model_update();
  endtask

  task automatic cycle(input logic v, input logic [1:0] s, input logic [15:0] d,
                       input logic [3:0] r);
    step_begin(v, s, d, r);
    step_end();
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 16'h0000, 4'hF);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_valid", {28'd0, vld}, 32'd0);
    check_val("rst_out1", {16'd0, out1}, 32'd0);
    check_val("rst_out4", {16'd0, out4}, 32'd0);
    check_val("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // First edge after reset release accepts; routing to all four channels.
    cycle(1'b1, 2'b00, 16'h1111, 4'h0);
    step_begin(1'b1, 2'b01, 16'h2222, 4'h0);
    check_val("route1", {16'd0, out1}, 32'h1111);
    step_end();
    cycle(1'b1, 2'b10, 16'h3333, 4'h0);
    cycle(1'b1, 2'b11, 16'h4444, 4'h0);
    step_begin(1'b0, 2'b00, 16'h0000, 4'h0);
    check_val("route_vld", {28'd0, vld}, 32'hF);
    check_val("route2", {16'd0, out2}, 32'h2222);
    check_val("route3", {16'd0, out3}, 32'h3333);
    check_val("route4", {16'd0, out4}, 32'h4444);
    step_end();
    drain();

    // Full/backpressure on channel 3.
    cycle(1'b1, 2'b10, 16'hA001, 4'h0);
    cycle(1'b1, 2'b10, 16'hA002, 4'h0);
    step_begin(1'b1, 2'b10, 16'hA003, 4'h0);
    check_val("full_rdy", {31'd0, in_ready}, 32'd0);
    step_end();
    step_begin(1'b1, 2'b10, 16'hA003, 4'h4);
    check_val("full_nopass", {31'd0, in_ready}, 32'd0);
    check_val("full_head", {16'd0, out3}, 32'hA001);
    step_end();
    step_begin(1'b1, 2'b10, 16'hA003, 4'h0);
    check_val("retry_rdy", {31'd0, in_ready}, 32'd1);
    step_end();
    step_begin(1'b0, 2'b10, 16'h0000, 4'h4);
    check_val("order1", {16'd0, out3}, 32'hA002);
    step_end();
    step_begin(1'b0, 2'b10, 16'h0000, 4'h4);
    check_val("order2", {16'd0, out3}, 32'hA003);
    step_end();
    drain();

    // Full channel 1 does not block channel 4.
    cycle(1'b1, 2'b00, 16'h0101, 4'h0);
    cycle(1'b1, 2'b00, 16'h0202, 4'h0);
    step_begin(1'b1, 2'b11, 16'hBEEF, 4'h0);
    check_val("indep_rdy", {31'd0, in_ready}, 32'd1);
    step_end();
    step_begin(1'b0, 2'b00, 16'h0000, 4'h0);
    check_val("indep_out4", {16'd0, out4}, 32'hBEEF);
    step_end();
    drain();

    // Simultaneous push and pop at count 1.
    cycle(1'b1, 2'b00, 16'h0005, 4'h0);
    cycle(1'b1, 2'b00, 16'h0006, 4'h1);
    step_begin(1'b0, 2'b00, 16'h0000, 4'h1);
    check_val("simul_out1", {16'd0, out1}, 32'h0006);
    step_end();
    step_begin(1'b0, 2'b00, 16'h0000, 4'h0);
    check_val("simul_cnt1", {31'd0, out1_valid}, 32'd0);
    step_end();

    // Reset mid-cycle with words in every channel.
    for (int k = 0; k < 4; k++) cycle(1'b1, k[1:0], 16'hC000 + 16'(k), 4'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_vld", {28'd0, vld}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      in_sel = k[1:0];
      #1;
      check_val("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    end
    for (int k = 0; k < 4; k++) mq[k].delete();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 2'b01, 16'h7777, 4'h0);
    step_begin(1'b0, 2'b00, 16'h0000, 4'h0);
    check_val("post_rst_push", {16'd0, out2}, 32'h7777);
    step_end();

    // Random soak.
    for (int i = 0; i < 10000; i++)
      cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            16'($urandom), 4'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
